// File: rtl/dual_port_bram.sv
// dual_port_bram
//   True dual-port synchronous block RAM. Two independent read/write ports
//   share one array of 2^ADDR_WIDTH words of DATA_WIDTH bits.
//
//   Behaviour:
//     - Reads are registered with one cycle of latency and are read-first:
//       a read returns the contents from before any write in the same cycle,
//       whether that write comes from its own port or from the other port.
//     - readData holds its value while readEnable is low.
//     - If both ports write the same address in one cycle, port 1 wins.
//     - Reset clears only the read-data registers and suppresses reads in
//       that cycle. Writes still complete, and the array is never cleared.
//
//   Ports:
//     clock                      rising-edge clock
//     reset                      synchronous, active-high
//     readEnable_1/2             per-port read request
//     writeEnable_1/2            per-port write request
//     address_1/2   [ADDR_WIDTH] per-port word address
//     writeData_1/2 [DATA_WIDTH] per-port write data
//     readData_1/2  [DATA_WIDTH] per-port registered read data
//     scan                       diagnostic dump enable
//
//   Optional feature (macro DUAL_PORT_BRAM_SCAN_EN):
//     A 32-bit cycle counter runs on the falling edge. While scan=1 and the
//     count is within [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], one dump of both
//     ports is printed per falling edge. When the macro is undefined, scan
//     is ignored.
module dual_port_bram #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  readEnable_1,
  input  logic                  writeEnable_1,
  input  logic [ADDR_WIDTH-1:0] address_1,
  input  logic [DATA_WIDTH-1:0] writeData_1,
  output logic [DATA_WIDTH-1:0] readData_1,
  input  logic                  readEnable_2,
  input  logic                  writeEnable_2,
  input  logic [ADDR_WIDTH-1:0] address_2,
  input  logic [DATA_WIDTH-1:0] writeData_2,
  output logic [DATA_WIDTH-1:0] readData_2,
  input  logic                  scan
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Port 2's write is dropped when it collides with a port 1 write.
  logic wr2_ok;
  assign wr2_ok = writeEnable_2 && !(writeEnable_1 && (address_1 == address_2));

  // Array writes ignore reset so that a write issued during reset still lands.
  always_ff @(posedge clock) begin
    if (writeEnable_1) mem[address_1] <= writeData_1;
    if (wr2_ok)        mem[address_2] <= writeData_2;
  end

  // Non-blocking reads sample the array before this edge's writes,
  // which gives read-first behaviour on both the same port and the other port.
  always_ff @(posedge clock) begin
    if (reset) begin
      readData_1 <= '0;
      readData_2 <= '0;
    end else begin
      if (readEnable_1) readData_1 <= mem[address_1];
      if (readEnable_2) readData_2 <= mem[address_2];
    end
  end

`ifdef DUAL_PORT_BRAM_SCAN_EN
  logic [31:0] cycles;

  always_ff @(negedge clock) begin
    if (reset) cycles <= 32'd0;
    else       cycles <= cycles + 32'd1;
  end

  always @(negedge clock) begin
    if (scan && ($signed({1'b0, cycles}) >= 33'(SCAN_CYCLES_MIN)) &&
        ($signed({1'b0, cycles}) <= 33'(SCAN_CYCLES_MAX))) begin
      $display("------ dual_port_bram core %0d cycle %0d ------", CORE, cycles);
      $display("  port1: readEnable=%b writeEnable=%b address=%h readData=%h writeData=%h",
               readEnable_1, writeEnable_1, address_1, readData_1, writeData_1);
      $display("  port2: readEnable=%b writeEnable=%b address=%h readData=%h writeData=%h",
               readEnable_2, writeEnable_2, address_2, readData_2, writeData_2);
    end
  end
`else
  logic unused_scan;
  assign unused_scan = scan;
`endif

endmodule

// File: tb/tb_dual_port_bram.sv
// tb_dual_port_bram
//   Directed testbench for dual_port_bram using its default parameters:
//   32-bit words and 256 locations. Stimulus is applied 1 ns after each rising
//   edge, and outputs are checked at the same point, after the edge that
//   completes an operation.
module tb_dual_port_bram;

  logic        clock = 1'b0;
  logic        reset;
  logic        readEnable_1, writeEnable_1, readEnable_2, writeEnable_2;
  logic [7:0]  address_1, address_2;
  logic [31:0] writeData_1, writeData_2;
  logic [31:0] readData_1, readData_2;
  logic        scan;

  int pass_cnt = 0;
  int total_cnt = 0;

  dual_port_bram dut (
    .clock(clock), .reset(reset),
    .readEnable_1(readEnable_1), .writeEnable_1(writeEnable_1),
    .address_1(address_1), .writeData_1(writeData_1), .readData_1(readData_1),
    .readEnable_2(readEnable_2), .writeEnable_2(writeEnable_2),
    .address_2(address_2), .writeData_2(writeData_2), .readData_2(readData_2),
    .scan(scan)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    readEnable_1 = 0; writeEnable_1 = 0; readEnable_2 = 0; writeEnable_2 = 0;
  endtask

  task automatic test_reset();
    reset = 1; readEnable_1 = 1; readEnable_2 = 1;
    address_1 = 8'h00; address_2 = 8'h00;
    tick(); tick();
    total_cnt++;
    if (readData_1 !== 32'h0) $display("FAIL reset_rd1 got=%h exp=%h", readData_1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (readData_2 !== 32'h0) $display("FAIL reset_rd2 got=%h exp=%h", readData_2, 32'h0);
    else pass_cnt++;
    reset = 0; idle();
    tick(); tick();
    total_cnt++;
    if (readData_1 !== 32'h0) $display("FAIL idle_rd1 got=%h exp=%h", readData_1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (readData_2 !== 32'h0) $display("FAIL idle_rd2 got=%h exp=%h", readData_2, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    writeEnable_1 = 1; address_1 = 8'h10; writeData_1 = 32'hDEADBEEF;
    tick();
    idle(); readEnable_2 = 1; address_2 = 8'h10;
    tick();
    idle();
    total_cnt++;
    if (readData_2 !== 32'hDEADBEEF) $display("FAIL basic_rd2 got=%h exp=%h", readData_2, 32'hDEADBEEF);
    else pass_cnt++;
    total_cnt++;
    if (readData_1 !== 32'h0) $display("FAIL basic_rd1_unchanged got=%h exp=%h", readData_1, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_read_first();
    writeEnable_1 = 1; address_1 = 8'h05; writeData_1 = 32'h11111111;
    tick();
    readEnable_1 = 1; writeData_1 = 32'h22222222;
    tick();
    total_cnt++;
    if (readData_1 !== 32'h11111111) $display("FAIL read_first_old got=%h exp=%h", readData_1, 32'h11111111);
    else pass_cnt++;
    writeEnable_1 = 0;
    tick();
    idle();
    total_cnt++;
    if (readData_1 !== 32'h22222222) $display("FAIL read_first_new got=%h exp=%h", readData_1, 32'h22222222);
    else pass_cnt++;
  endtask

  task automatic test_cross_port();
    writeEnable_1 = 1; address_1 = 8'h30; writeData_1 = 32'h0A0A0A0A;
    tick();
    writeData_1 = 32'hB0B0B0B0; readEnable_2 = 1; address_2 = 8'h30;
    tick();
    total_cnt++;
    if (readData_2 !== 32'h0A0A0A0A) $display("FAIL cross_old got=%h exp=%h", readData_2, 32'h0A0A0A0A);
    else pass_cnt++;
    writeEnable_1 = 0;
    tick();
    idle();
    total_cnt++;
    if (readData_2 !== 32'hB0B0B0B0) $display("FAIL cross_new got=%h exp=%h", readData_2, 32'hB0B0B0B0);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    writeEnable_1 = 1; address_1 = 8'h20; writeData_1 = 32'hAAAAAAAA;
    writeEnable_2 = 1; address_2 = 8'h20; writeData_2 = 32'h55555555;
    tick();
    idle(); readEnable_1 = 1; readEnable_2 = 1;
    tick();
    idle();
    total_cnt++;
    if (readData_1 !== 32'hAAAAAAAA) $display("FAIL collision_rd1 got=%h exp=%h", readData_1, 32'hAAAAAAAA);
    else pass_cnt++;
    total_cnt++;
    if (readData_2 !== 32'hAAAAAAAA) $display("FAIL collision_rd2 got=%h exp=%h", readData_2, 32'hAAAAAAAA);
    else pass_cnt++;
    // Writes from both ports to different addresses must both land.
    writeEnable_1 = 1; address_1 = 8'h40; writeData_1 = 32'h00000001;
    writeEnable_2 = 1; address_2 = 8'h41; writeData_2 = 32'h00000002;
    tick();
    idle(); readEnable_1 = 1; address_1 = 8'h41; readEnable_2 = 1; address_2 = 8'h40;
    tick();
    idle();
    total_cnt++;
    if (readData_1 !== 32'h00000002) $display("FAIL dual_write_rd1 got=%h exp=%h", readData_1, 32'h00000002);
    else pass_cnt++;
    total_cnt++;
    if (readData_2 !== 32'h00000001) $display("FAIL dual_write_rd2 got=%h exp=%h", readData_2, 32'h00000001);
    else pass_cnt++;
  endtask

  task automatic test_boundaries_hold();
    writeEnable_1 = 1; address_1 = 8'h00; writeData_1 = 32'h12345678;
    writeEnable_2 = 1; address_2 = 8'hFF; writeData_2 = 32'h87654321;
    tick();
    idle(); readEnable_1 = 1; address_1 = 8'hFF; readEnable_2 = 1; address_2 = 8'h00;
    tick();
    idle();
    total_cnt++;
    if (readData_1 !== 32'h87654321) $display("FAIL bound_ff got=%h exp=%h", readData_1, 32'h87654321);
    else pass_cnt++;
    total_cnt++;
    if (readData_2 !== 32'h12345678) $display("FAIL bound_00 got=%h exp=%h", readData_2, 32'h12345678);
    else pass_cnt++;
    // Change the addresses and overwrite 0xFF while reads are disabled.
    writeEnable_1 = 1; address_1 = 8'hFF; writeData_1 = 32'h0BADF00D; address_2 = 8'h10;
    tick();
    idle();
    tick();
    total_cnt++;
    if (readData_1 !== 32'h87654321) $display("FAIL hold_rd1 got=%h exp=%h", readData_1, 32'h87654321);
    else pass_cnt++;
    total_cnt++;
    if (readData_2 !== 32'h12345678) $display("FAIL hold_rd2 got=%h exp=%h", readData_2, 32'h12345678);
    else pass_cnt++;
    readEnable_1 = 1;
    tick();
    idle();
    total_cnt++;
    if (readData_1 !== 32'h0BADF00D) $display("FAIL hold_write_landed got=%h exp=%h", readData_1, 32'h0BADF00D);
    else pass_cnt++;
  endtask

  task automatic test_reset_write();
    reset = 1;
    writeEnable_1 = 1; address_1 = 8'h50; writeData_1 = 32'hCAFEF00D;
    readEnable_2 = 1; address_2 = 8'h10;
    tick();
    total_cnt++;
    if (readData_1 !== 32'h0) $display("FAIL rst_clear_rd1 got=%h exp=%h", readData_1, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (readData_2 !== 32'h0) $display("FAIL rst_suppress_rd2 got=%h exp=%h", readData_2, 32'h0);
    else pass_cnt++;
    reset = 0; idle(); readEnable_1 = 1;
    tick();
    idle();
    total_cnt++;
    if (readData_1 !== 32'hCAFEF00D) $display("FAIL rst_write_kept got=%h exp=%h", readData_1, 32'hCAFEF00D);
    else pass_cnt++;
    total_cnt++;
    if (readData_2 !== 32'h0) $display("FAIL rst_rd2_stays0 got=%h exp=%h", readData_2, 32'h0);
    else pass_cnt++;
  endtask

  initial begin
    scan = 0; reset = 0;
    idle();
    address_1 = 0; address_2 = 0; writeData_1 = 0; writeData_2 = 0;
    #1;
    test_reset();
    test_basic();
    test_read_first();
    test_cross_port();
    test_collision();
    test_boundaries_hold();
    test_reset_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
